// File: rtl/fifo_arb_pkg.sv
// Shared defaults and index type for the FIFO write-port arbiter.
// Holds only constants and a typedef; no ports.
package fifo_arb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit scanning base+1, base+2, ...
// Ports: req_i (request vector), base_i (last winner), found_o, idx_o.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(base_i) + k) % N);
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded burst lock for a FIFO.
// Ports: clk_i, rst_i, req_valid_i/req_data_i/req_ready_o (producers),
//        fifo_full_i/fifo_wr_o/fifo_din_o (FIFO), gnt_vld_o/gnt_idx_o.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DW-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_wr_o,
    output logic [DW-1:0]              fifo_din_o,
    output logic                       gnt_vld_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          lock_hit;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] g;
    logic          gnt_vld;
    logic          accept;
    logic [CW-1:0] base_cnt;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req_valid_i),
        .base_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        lock_hit = locked_q & req_valid_i[owner_q];
        g        = lock_hit ? owner_q : pick_idx;
        gnt_vld  = ~rst_i & (lock_hit | pick_found);
        accept   = gnt_vld & ~fifo_full_i;

        req_ready_o = '0;
        if (accept) begin
            req_ready_o[g] = 1'b1;
        end

        fifo_din_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vld && g == IW'(i)) begin
                fifo_din_o = req_data_i[i*DW +: DW];
            end
        end

        fifo_wr_o = accept;
        gnt_vld_o = gnt_vld;
        gnt_idx_o = g;
    end

    always_comb begin
        owner_d  = owner_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        base_cnt = '0;

        // Owner went away mid-burst: release and rotate past it.
        if (locked_q && !req_valid_i[owner_q]) begin
            locked_d = 1'b0;
            cnt_d    = '0;
            last_d   = owner_q;
        end

        // A beat that does not continue a lock starts a fresh burst at 0.
        if (accept) begin
            base_cnt = lock_hit ? cnt_q : '0;
            if (int'(base_cnt) + 1 == MAX_BURST) begin
                locked_d = 1'b0;
                cnt_d    = '0;
                last_d   = g;
            end else begin
                owner_d  = g;
                locked_d = 1'b1;
                cnt_d    = base_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            last_q   <= IW'(NUM_REQ - 1);
        end else begin
            owner_q  <= owner_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

endmodule
